// File: rtl/sdam_rw.sv
// sdam_rw: serial address/data receiver with read/write frames.
// Frames arrive on sda, clocked by scl, in this order:
//   start 0, mode bit (1 = write, 0 = read), ADDR_W address bits LSB first,
//   then DATA_W data bits LSB first.
// Write data comes from the master. Read data is driven back by this block
// through sda_o/sda_oe. The register file is DEPTH words deep.
module sdam_rw #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16,
   parameter int DEPTH  = 32
) (
   input  logic              scl,
   input  logic              reset,
   input  logic              sda_i,
   output logic              sda_o,
   output logic              sda_oe,
   output logic              avalid,
   output logic [ADDR_W-1:0] aout,
   output logic              dvalid,
   output logic [DATA_W-1:0] dout,
   output logic              rd_mode,
   output logic              err
);

   localparam int MAXW  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
   localparam int CNT_W = $clog2(MAXW) + 1;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [CNT_W-1:0] A_LAST  = CNT_W'(ADDR_W - 1);
   localparam logic [CNT_W-1:0] D_LAST  = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] D_DONE  = CNT_W'(DATA_W);

   typedef enum logic [2:0] {IDLE, MODE, ADDR, WDATA, RDATA} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [ADDR_W-1:0]  ashift;
   logic [DATA_W-1:0]  dshift;
   logic [DATA_W-1:0]  rshift;
   logic [DATA_W-1:0]  rword;
   logic [DATA_W-1:0]  mem [DEPTH];

   logic [ADDR_W-1:0]  addr_full;
   logic [DATA_W-1:0]  data_full;
   logic [DATA_W-1:0]  rd_word;
   logic [IDX_W-1:0]   ridx;
   logic [IDX_W-1:0]   widx;
   logic               mem_we;

   // New bit enters at the MSB, so after W shifts the first bit sits at bit 0.
   function automatic logic [ADDR_W-1:0] shift_addr(input logic [ADDR_W-1:0] cur,
                                                    input logic b);
      logic [ADDR_W:0] t;
      t = {b, cur} >> 1;
      return t[ADDR_W-1:0];
   endfunction

   function automatic logic [DATA_W-1:0] shift_data(input logic [DATA_W-1:0] cur,
                                                    input logic b);
      logic [DATA_W:0] t;
      t = {b, cur} >> 1;
      return t[DATA_W-1:0];
   endfunction

   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return ({1'b0, a} < DEPTH_L);
   endfunction

   // The assembled fields include the bit being sampled on this edge.
   assign addr_full = shift_addr(ashift, sda_i);
   assign data_full = shift_data(dshift, sda_i);
   assign ridx      = addr_full[IDX_W-1:0];
   assign widx      = aout[IDX_W-1:0];
   assign rd_word   = in_range(addr_full) ? mem[ridx] : {DATA_W{1'b1}};
   assign mem_we    = (state == WDATA) && (cnt == D_LAST) && in_range(aout);

   // Register file: cleared by reset, written only on the last write-data edge.
   always_ff @(posedge scl or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (mem_we) begin
         mem[widx] <= data_full;
      end
   end

   // Frame FSM with registered strobes and sda driver.
   always_ff @(posedge scl or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         ashift  <= '0;
         dshift  <= '0;
         rshift  <= '0;
         rword   <= '0;
         sda_o   <= 1'b1;
         sda_oe  <= 1'b0;
         avalid  <= 1'b0;
         aout    <= '0;
         dvalid  <= 1'b0;
         dout    <= '0;
         rd_mode <= 1'b0;
         err     <= 1'b0;
      end else begin
         avalid <= 1'b0;
         dvalid <= 1'b0;
         err    <= 1'b0;
         case (state)
            IDLE: begin
               if (!sda_i) state <= MODE;
            end
            MODE: begin
               rd_mode <= ~sda_i;
               cnt     <= '0;
               state   <= ADDR;
            end
            ADDR: begin
               ashift <= addr_full;
               if (cnt == A_LAST) begin
                  aout   <= addr_full;
                  avalid <= 1'b1;
                  if (rd_mode) begin
                     // Bit 0 goes out on this same edge; cnt tracks the next bit index.
                     sda_oe <= 1'b1;
                     sda_o  <= rd_word[0];
                     rshift <= rd_word >> 1;
                     rword  <= rd_word;
                     err    <= ~in_range(addr_full);
                     cnt    <= CNT_W'(1);
                     state  <= RDATA;
                  end else begin
                     cnt   <= '0;
                     state <= WDATA;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            WDATA: begin
               dshift <= data_full;
               if (cnt == D_LAST) begin
                  dout   <= data_full;
                  dvalid <= 1'b1;
                  err    <= ~in_range(aout);
                  state  <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RDATA: begin
               // sda_i is ignored here; the line is ours until the last bit has had a full cycle.
               if (cnt == D_DONE) begin
                  sda_oe <= 1'b0;
                  sda_o  <= 1'b1;
                  dout   <= rword;
                  dvalid <= 1'b1;
                  state  <= IDLE;
               end else begin
                  sda_o  <= rshift[0];
                  rshift <= rshift >> 1;
                  cnt    <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sdam_rw.sv
// Directed bench for sdam_rw: default instance (8/16/32) and a small one (4/8/16).
module tb_sdam_rw;

   logic scl = 1'b0;
   logic reset = 1'b1;
   logic m_a = 1'b1;
   logic m_b = 1'b1;
   logic sel = 1'b0;

   logic        a_o, a_oe, a_avalid, a_dvalid, a_rd, a_err;
   logic [7:0]  a_aout;
   logic [15:0] a_dout;
   logic        b_o, b_oe, b_avalid, b_dvalid, b_rd, b_err;
   logic [3:0]  b_aout;
   logic [7:0]  b_dout;

   // open-drain line: master and block can both pull low
   wire sda_a = m_a & (a_oe ? a_o : 1'b1);
   wire sda_b = m_b & (b_oe ? b_o : 1'b1);

   sdam_rw #(.ADDR_W(8), .DATA_W(16), .DEPTH(32)) dut_a (
      .scl(scl), .reset(reset), .sda_i(sda_a), .sda_o(a_o), .sda_oe(a_oe),
      .avalid(a_avalid), .aout(a_aout), .dvalid(a_dvalid), .dout(a_dout),
      .rd_mode(a_rd), .err(a_err));

   sdam_rw #(.ADDR_W(4), .DATA_W(8), .DEPTH(16)) dut_b (
      .scl(scl), .reset(reset), .sda_i(sda_b), .sda_o(b_o), .sda_oe(b_oe),
      .avalid(b_avalid), .aout(b_aout), .dvalid(b_dvalid), .dout(b_dout),
      .rd_mode(b_rd), .err(b_err));

   always #5 scl = ~scl;

   int cyc = 0;
   always @(posedge scl) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   int t_start = 0;

   wire        v_avalid = sel ? b_avalid : a_avalid;
   wire        v_dvalid = sel ? b_dvalid : a_dvalid;
   wire        v_err    = sel ? b_err    : a_err;
   wire        v_rd     = sel ? b_rd     : a_rd;
   wire        v_oe     = sel ? b_oe     : a_oe;
   wire        v_o      = sel ? b_o      : a_o;
   wire [31:0] v_aout   = sel ? 32'(b_aout) : 32'(a_aout);
   wire [31:0] v_dout   = sel ? 32'(b_dout) : 32'(a_dout);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pat(input int i);
      logic [7:0] b;
      b = 8'(i);
      return {16'h0, b ^ 8'h3C, b};
   endfunction

   task automatic drive(input logic b);
      if (sel) m_b = b;
      else     m_a = b;
   endtask

   task automatic step(input logic b);
      @(posedge scl);
      #1;
      drive(b);
   endtask

   task automatic start_frame();
      step(1'b0);
      t_start = cyc;
   endtask

   task automatic write_frame(input logic [31:0] a, input logic [31:0] d,
                              input logic exp_err, input logic next_start,
                              input logic started);
      int aw, dw;
      aw = sel ? 4 : 8;
      dw = sel ? 8 : 16;
      if (!started) start_frame();
      step(1'b1);
      for (int i = 0; i < aw; i++) step(a[i]);
      @(posedge scl);
      #1;
      chk("w_avalid", 32'(v_avalid), 32'd1);
      chk("w_aout", v_aout, a);
      drive(d[0]);
      for (int i = 1; i < dw; i++) step(d[i]);
      @(posedge scl);
      #1;
      chk("w_dvalid", 32'(v_dvalid), 32'd1);
      chk("w_dout", v_dout, d);
      chk("w_err", 32'(v_err), 32'(exp_err));
      chk("w_rdmode", 32'(v_rd), 32'd0);
      chk("w_len", 32'(cyc - t_start), 32'(2 + aw + dw));
      if (next_start) begin
         drive(1'b0);
         t_start = cyc;
      end else begin
         drive(1'b1);
      end
   endtask

   task automatic read_frame(input logic [31:0] a, input logic [31:0] exp,
                             input logic exp_err, input logic started);
      int aw, dw, oe_n;
      logic [31:0] got;
      aw = sel ? 4 : 8;
      dw = sel ? 8 : 16;
      if (!started) start_frame();
      step(1'b0);
      for (int i = 0; i < aw; i++) step(a[i]);
      @(posedge scl);
      #1;
      chk("r_avalid", 32'(v_avalid), 32'd1);
      chk("r_aout", v_aout, a);
      chk("r_err", 32'(v_err), 32'(exp_err));
      chk("r_rdmode", 32'(v_rd), 32'd1);
      drive(1'b1);
      got = '0;
      got[0] = v_o;
      oe_n = v_oe ? 1 : 0;
      for (int i = 1; i < dw; i++) begin
         @(posedge scl);
         #1;
         if (v_oe) oe_n++;
         got[i] = v_o;
      end
      @(posedge scl);
      #1;
      chk("r_dvalid", 32'(v_dvalid), 32'd1);
      chk("r_dout", v_dout, exp);
      chk("r_bits", got, exp);
      chk("r_oe_cycles", 32'(oe_n), 32'(dw));
      chk("r_oe_off", 32'(v_oe), 32'd0);
      chk("r_o_idle", 32'(v_o), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d expected=finish", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      int dv_seen;
      // reset state
      reset = 1'b1;
      #12;
      chk("rst_sda_o", 32'(a_o), 32'd1);
      chk("rst_sda_oe", 32'(a_oe), 32'd0);
      chk("rst_avalid", 32'(a_avalid), 32'd0);
      chk("rst_aout", 32'(a_aout), 32'd0);
      chk("rst_dvalid", 32'(a_dvalid), 32'd0);
      chk("rst_dout", 32'(a_dout), 32'd0);
      chk("rst_rdmode", 32'(a_rd), 32'd0);
      chk("rst_err", 32'(a_err), 32'd0);
      chk("rst_b_sda_o", 32'(b_o), 32'd1);
      @(negedge scl);
      reset = 1'b0;

      // never-written word reads as zero
      read_frame(32'd7, 32'h0000, 1'b0, 1'b0);

      // fill every word, then overwrite addr 5
      for (int i = 0; i < 32; i++) write_frame(32'(i), pat(i), 1'b0, 1'b0, 1'b0);
      write_frame(32'd5, 32'hA55A, 1'b0, 1'b0, 1'b0);

      // back-to-back write then read, no idle gap
      write_frame(32'd3, 32'h1234, 1'b0, 1'b1, 1'b0);
      read_frame(32'd3, 32'h1234, 1'b0, 1'b1);

      // out of range: write discarded, read returns all ones
      write_frame(32'd40, 32'hBEEF, 1'b1, 1'b0, 1'b0);
      read_frame(32'd40, 32'hFFFF, 1'b1, 1'b0);
      read_frame(32'd8, pat(8), 1'b0, 1'b0);
      read_frame(32'd5, 32'hA55A, 1'b0, 1'b0);
      read_frame(32'd31, pat(31), 1'b0, 1'b0);

      // reset in the middle of a read of addr 3
      start_frame();
      step(1'b0);
      for (int i = 0; i < 8; i++) step(((32'd3 >> i) & 32'd1) != 0);
      @(posedge scl);
      #1;
      chk("mr_avalid", 32'(a_avalid), 32'd1);
      chk("mr_oe_on", 32'(a_oe), 32'd1);
      drive(1'b1);
      repeat (4) @(posedge scl);
      #3;
      reset = 1'b1;
      #1;
      chk("mr_oe_drop", 32'(a_oe), 32'd0);
      chk("mr_sda_o", 32'(a_o), 32'd1);
      chk("mr_dvalid", 32'(a_dvalid), 32'd0);
      @(negedge scl);
      reset = 1'b0;
      dv_seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge scl);
         #1;
         if (a_dvalid || a_oe) dv_seen++;
      end
      chk("mr_quiet", 32'(dv_seen), 32'd0);
      read_frame(32'd3, 32'h0000, 1'b0, 1'b0);
      read_frame(32'd5, 32'h0000, 1'b0, 1'b0);

      // small instance: 4-bit address, 8-bit data, 14-edge write frame
      sel = 1'b1;
      write_frame(32'hF, 32'h5A, 1'b0, 1'b0, 1'b0);
      read_frame(32'hF, 32'h5A, 1'b0, 1'b0);
      read_frame(32'h2, 32'h00, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sdam_rw.md
Name: sdam_rw

Overview:
- Parametrised successor to the serial address/data receiver (SDAM).
- Single-wire framed protocol on sda, clocked by scl; adds a mode bit so frames can be writes or reads.
- Backed by an internal register file of DEPTH words; on reads the block drives data back onto the shared open-drain line through sda_o/sda_oe.
- Sits between the serial master (bench or host bridge) and downstream logic, which consumes the avalid/aout and dvalid/dout strobes.

Parameters:
- ADDR_W, 8, address field width in bits.
- DATA_W, 16, data field width in bits.
- DEPTH, 32, register-file words, 1..2^ADDR_W; addresses >= DEPTH are out of range.

Ports:
- scl  input  1  serial clock, the block's only clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- sda_i  input  1  sampled value of the shared sda line.
- sda_o  output  1  value driven onto sda when sda_oe=1.
- sda_oe  output  1  sda output enable; the top level tristates sda when 0, and a pullup holds the line high.
- avalid  output  1  one-cycle strobe: address field captured.
- aout  output  ADDR_W  captured address, held until the next avalid.
- dvalid  output  1  one-cycle strobe: data transfer complete.
- dout  output  DATA_W  written or read data, held until the next dvalid.
- rd_mode  output  1  mode of the current or last frame: 1 = read, 0 = write.
- err  output  1  one-cycle strobe: access to an out-of-range address.

Behaviour:
- Interface: one clock (scl); reset is asynchronous and active-high.
- Reset values: all outputs are 0 except sda_o, which resets to 1. State = IDLE, shift registers = 0, every register-file word = 0.
- Reset asserted mid-frame: the frame is aborted immediately, sda_oe drops asynchronously, and no strobe is issued.
- Master timing: the master changes sda shortly after a rising scl edge. The block samples sda_i on the next rising edge.
- Frame format: idle 1s, start 0, mode bit (1 = write, 0 = read), then ADDR_W address bits LSB first. A write frame follows with DATA_W data bits LSB first, driven by the master. A read frame follows with DATA_W bits LSB first, driven by the block.
- States: IDLE, MODE, ADDR, WDATA, RDATA.
- IDLE: sda_i=1 stays in IDLE. sda_i=0 goes to MODE.
- MODE: the sampled bit sets rd_mode = ~bit, then go to ADDR. The address bit counter clears.
- ADDR: shift address bits LSB-first for ADDR_W edges.
- On the edge that samples the last address bit:
  - aout is loaded and avalid=1 for one cycle.
  - Write mode: go to WDATA.
  - Read mode: go to RDATA. On that same edge, sda_oe=1 and sda_o = bit 0 of the read word.
- WDATA: shift DATA_W bits LSB-first. On the edge that samples the last bit:
  - If the address is in range, write mem[aout].
  - dout = the assembled word and dvalid=1 for one cycle, even when out of range.
  - Out of range: the write is discarded and err=1 in the same cycle as dvalid.
  - Next state is IDLE.
- RDATA:
  - Read word = mem[aout] if in range, else all 1s. Out of range raises err=1 on the same edge as avalid.
  - Each later edge presents the next bit on sda_o. After bit DATA_W-1 has been driven for one full cycle, the next edge sets sda_oe=0 and sda_o=1.
  - That same edge sets dout = read word and dvalid=1 for one cycle, then go to IDLE.
  - sda_i is ignored while sda_oe=1.
- Latency:
  - Write: dvalid is high in the cycle after the edge that samples the last data bit. Frame length is 2+ADDR_W+DATA_W edges from the start bit.
  - Read: dvalid follows DATA_W drive cycles after avalid.
- Back-to-back frames: a 0 sampled in IDLE on the cycle right after a frame completes starts a new frame; no idle gap is required.
- Bit counters are sized ceil(log2(max(ADDR_W,DATA_W)))+1 and do not wrap within a frame.
- The register file is written only from WDATA; there is no read-modify-write.

Test Plan:
- Reset then write frames to addr 0..31 with PAT values, e.g. addr 5, data 16'hA55A -> avalid with aout=8'h05, then dvalid with dout=16'hA55A, err=0, rd_mode=0.
- Write addr 3 = 16'h1234, then read addr 3 -> sda_oe high for exactly 16 cycles. Bits on sda_o LSB-first reassemble to 16'h1234. dvalid with dout=16'h1234, then sda_oe=0.
- Write addr 40 (DEPTH=32), data 16'hBEEF -> dvalid with err=1. A read of addr 40 then returns 16'hFFFF with err=1, and mem[0..31] is unchanged.
- Read addr 7 after reset, never written -> 16'h0000 driven. Back-to-back write then read with no idle gap -> both frames decode correctly.
- Assert reset during the RDATA of a read of addr 3 -> sda_oe=0 immediately, no dvalid, all words reset to 0. A subsequent read of addr 3 returns 16'h0000.
- Parameter sweep ADDR_W=4, DATA_W=8, DEPTH=16 -> write addr 4'hF data 8'h5A, then read it back -> 8'h5A, frame length 14 edges for the write.
